// File: rtl/waveform_buffer_reader.sv
// Pops one event header, then streams its samples out of the waveform RAM through a 2-entry skid buffer.
// First word is valid 4 cycles after the header pop; out_valid never waits on out_ready.
module waveform_buffer_reader #(
   parameter int P_DATA_WIDTH = 22,
   parameter int P_ADR_WIDTH  = 12,
   parameter int P_HDR_WIDTH  = 80
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    hdr_empty,
   input  logic [P_HDR_WIDTH-1:0]  hdr_data,
   output logic                    hdr_rdreq,
   output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
   input  logic [P_DATA_WIDTH-1:0] wvb_data,
   output logic [P_HDR_WIDTH-1:0]  out_hdr,
   output logic [P_DATA_WIDTH-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_sof,
   output logic                    out_eof,
   output logic                    eoe_err,
   output logic                    busy
);
   localparam int A = P_ADR_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_HPOP, S_HCAP, S_READ, S_DRAIN} state_t;

   typedef struct packed {
      logic [P_DATA_WIDTH-1:0] dat;
      logic                    sof;
      logic                    eof;
   } word_t;

   state_t                 r_state, w_state_nxt;
   logic [P_HDR_WIDTH-1:0] r_hdr;
   logic [A-1:0]           r_addr, r_stop;
   logic [A:0]             r_remain;
   logic                   r_first;
   logic                   r_inf, r_inf_sof, r_inf_eof;
   logic [1:0]             r_occ;
   word_t                  r_sk0, r_sk1;

   logic                   w_pop, w_room, w_issue;
   logic [A-1:0]           w_start_in, w_stop_in;
   logic [A:0]             w_remain_init;
   word_t                  w_new;

   assign w_start_in    = hdr_data[A-1:0];
   assign w_stop_in     = hdr_data[2*A-1:A];
   // Span is taken modulo 2^A so a stop below start wraps through the end of the RAM.
   assign w_remain_init = {1'b0, w_stop_in - w_start_in} + (A+1)'(1);
   assign w_pop         = out_valid & out_ready;
   assign w_room        = ({1'b0, r_occ} + {2'b00, r_inf}) < (3'd2 + {2'b00, w_pop});
   assign w_new         = '{dat: wvb_data, sof: r_inf_sof, eof: r_inf_eof};

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         S_IDLE:  if (en && !hdr_empty) w_state_nxt = S_HPOP;
         S_HPOP:  w_state_nxt = S_HCAP;
         S_HCAP:  w_state_nxt = S_READ;
         S_READ: begin
            w_issue = w_room;
            if (w_room && r_remain == (A+1)'(1)) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: if (!r_inf && r_occ == {1'b0, w_pop}) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_hdr     <= '0;
         r_addr    <= '0;
         r_stop    <= '0;
         r_remain  <= '0;
         r_first   <= 1'b0;
         r_inf     <= 1'b0;
         r_inf_sof <= 1'b0;
         r_inf_eof <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_inf     <= w_issue;
         r_inf_sof <= r_first;
         r_inf_eof <= (r_addr == r_stop);
         if (r_state == S_HCAP) begin
            r_hdr    <= hdr_data;
            r_addr   <= w_start_in;
            r_stop   <= w_stop_in;
            r_remain <= w_remain_init;
            r_first  <= 1'b1;
         end
         if (w_issue) begin
            r_addr   <= r_addr + A'(1);
            r_remain <= r_remain - (A+1)'(1);
            r_first  <= 1'b0;
         end
      end
   end

   // Head entry r_sk0 drives the output; r_sk1 absorbs the word that was already in flight when ready dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ <= 2'd0;
         r_sk0 <= '0;
         r_sk1 <= '0;
      end else begin
         case ({r_inf, w_pop})
            2'b10: begin
               if (r_occ == 2'd0) r_sk0 <= w_new;
               else               r_sk1 <= w_new;
               r_occ <= r_occ + 2'd1;
            end
            2'b01: begin
               r_sk0 <= r_sk1;
               r_occ <= r_occ - 2'd1;
            end
            2'b11: begin
               if (r_occ == 2'd1) begin
                  r_sk0 <= w_new;
               end else begin
                  r_sk0 <= r_sk1;
                  r_sk1 <= w_new;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid   = (r_occ != 2'd0);
   assign out_data    = r_sk0.dat;
   assign out_sof     = out_valid & r_sk0.sof;
   assign out_eof     = out_valid & r_sk0.eof;
   assign eoe_err     = w_pop & (r_sk0.dat[0] != r_sk0.eof);
   assign out_hdr     = r_hdr;
   assign wvb_rd_addr = r_addr;
   assign hdr_rdreq   = (r_state == S_HPOP);
   assign busy        = (r_state != S_IDLE);
endmodule
